// File: rtl/ercm_pkg.sv
`default_nettype none
// ============================================================================
// ercm_pkg : shared widths, column masks and reference arithmetic (Rev 1.0)
// ============================================================================
package ercm_pkg;

  localparam int MAX_W  = 32;
  localparam int MAX_PW = 2 * MAX_W;

  function automatic int lvl_w(input int w);
    return $clog2(2 * w);
  endfunction

  // Bit c set when product column c lies below level k and inside the 2w-bit product.
  function automatic logic [MAX_PW-1:0] col_lo_mask(input logic [7:0] k, input int w);
    logic [MAX_PW-1:0] m;
    m = '0;
    for (int c = 0; c < MAX_PW; c++) begin
      if ((c < int'(k)) && (c < 2 * w)) m[c] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [MAX_PW-1:0] approx_mul(input logic [MAX_W-1:0] a,
                                                   input logic [MAX_W-1:0] b,
                                                   input logic [7:0]       k,
                                                   input int               w);
    logic [MAX_PW-1:0] mask;
    logic [MAX_PW-1:0] row;
    logic [MAX_PW-1:0] hi;
    logic [MAX_PW-1:0] lo;
    mask = col_lo_mask(k, w);
    hi   = '0;
    lo   = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if ((i < w) && a[i]) begin
        row = {{MAX_W{1'b0}}, b} << i;
        hi  = hi + (row & ~mask);
        lo  = lo | (row & mask);
      end
    end
    return hi + lo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ercm_pp_col.sv
`default_nettype none
// ============================================================================
// ercm_pp_col : column compression of the partial-product matrix (Rev 1.0)
// ============================================================================
module ercm_pp_col
  import ercm_pkg::*;
#(
  parameter int W  = 8,
  parameter int LW = lvl_w(W)
) (
  input  logic [W*W-1:0] pp,
  input  logic [LW-1:0]  lvl,
  output logic [2*W-1:0] hi0,
  output logic [2*W-1:0] hi1,
  output logic [2*W-1:0] lo,
  output logic [2*W-1:0] exact
);

  localparam int PW = 2 * W;

  logic [PW-1:0] lo_mask;
  logic [PW-1:0] row;

  assign lo_mask = PW'(col_lo_mask(8'(lvl), W));

  // Row i shifted by i puts pp(i,j) on column i+j, so masking rows splits columns.
  always_comb begin
    hi0   = '0;
    hi1   = '0;
    lo    = '0;
    exact = '0;
    row   = '0;
    for (int i = 0; i < W; i++) begin
      row = PW'(pp[i*W +: W]) << i;
      if (i < W / 2) hi0 = hi0 + (row & ~lo_mask);
      else           hi1 = hi1 + (row & ~lo_mask);
      lo    = lo | (row & lo_mask);
      exact = exact + row;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ercm_pipe_mult.sv
`default_nettype none
// ============================================================================
// ercm_pipe_mult : 3-stage valid/ready OR-compression approximate multiplier
// Rev 1.0
// ============================================================================
module ercm_pipe_mult
  import ercm_pkg::*;
#(
  parameter int W  = 8,
  parameter int LW = lvl_w(W),
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [LW-1:0]  in_lvl,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [2*W-1:0] out_p,
  output logic [2*W-1:0] out_err,
  output logic [LW-1:0]  out_lvl,
  output logic [CW-1:0]  stat_cnt,
  input  logic           stat_clr
);

  localparam int PW = 2 * W;

  logic           s1_vld_q, s1_vld_d;
  logic [W*W-1:0] s1_pp_q, s1_pp_d;
  logic [LW-1:0]  s1_lvl_q, s1_lvl_d;

  logic           s2_vld_q, s2_vld_d;
  logic [PW-1:0]  s2_hi0_q, s2_hi0_d;
  logic [PW-1:0]  s2_hi1_q, s2_hi1_d;
  logic [PW-1:0]  s2_lo_q, s2_lo_d;
  logic [PW-1:0]  s2_exact_q, s2_exact_d;
  logic [LW-1:0]  s2_lvl_q, s2_lvl_d;

  logic           s3_vld_q, s3_vld_d;
  logic [PW-1:0]  s3_p_q, s3_p_d;
  logic [PW-1:0]  s3_err_q, s3_err_d;
  logic [LW-1:0]  s3_lvl_q, s3_lvl_d;

  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W*W-1:0] pp_in;
  logic [PW-1:0]  col_hi0, col_hi1, col_lo, col_exact;
  logic [PW-1:0]  sum_p;
  logic           s1_free, s2_free, s3_free, out_xfer;

  always_comb begin
    pp_in = '0;
    for (int i = 0; i < W; i++) begin
      pp_in[i*W +: W] = in_b & {W{in_a[i]}};
    end
  end

  ercm_pp_col #(
    .W  (W),
    .LW (LW)
  ) u_pp_col (
    .pp    (s1_pp_q),
    .lvl   (s1_lvl_q),
    .hi0   (col_hi0),
    .hi1   (col_hi1),
    .lo    (col_lo),
    .exact (col_exact)
  );

  // Free-chain from the output back lets a stall release every stage in one cycle.
  always_comb begin
    s3_free  = !s3_vld_q || out_rdy;
    s2_free  = !s2_vld_q || s3_free;
    s1_free  = !s1_vld_q || s2_free;
    out_xfer = s3_vld_q && out_rdy;
    sum_p    = s2_hi0_q + s2_hi1_q + s2_lo_q;

    s1_vld_d   = s1_vld_q;
    s1_pp_d    = s1_pp_q;
    s1_lvl_d   = s1_lvl_q;
    s2_vld_d   = s2_vld_q;
    s2_hi0_d   = s2_hi0_q;
    s2_hi1_d   = s2_hi1_q;
    s2_lo_d    = s2_lo_q;
    s2_exact_d = s2_exact_q;
    s2_lvl_d   = s2_lvl_q;
    s3_vld_d   = s3_vld_q;
    s3_p_d     = s3_p_q;
    s3_err_d   = s3_err_q;
    s3_lvl_d   = s3_lvl_q;
    cnt_d      = cnt_q;

    if (s1_free) begin
      s1_vld_d = in_vld;
      if (in_vld) begin
        s1_pp_d  = pp_in;
        s1_lvl_d = in_lvl;
      end
    end

    if (s2_free) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_hi0_d   = col_hi0;
        s2_hi1_d   = col_hi1;
        s2_lo_d    = col_lo;
        s2_exact_d = col_exact;
        s2_lvl_d   = s1_lvl_q;
      end
    end

    if (s3_free) begin
      s3_vld_d = s2_vld_q;
      if (s2_vld_q) begin
        s3_p_d   = sum_p;
        s3_err_d = s2_exact_q - sum_p;
        s3_lvl_d = s2_lvl_q;
      end
    end

    if (stat_clr) begin
      cnt_d = '0;
    end else if (out_xfer && (s3_err_q != '0) && !(&cnt_q)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_pp_q    <= '0;
      s1_lvl_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_hi0_q   <= '0;
      s2_hi1_q   <= '0;
      s2_lo_q    <= '0;
      s2_exact_q <= '0;
      s2_lvl_q   <= '0;
      s3_vld_q   <= 1'b0;
      s3_p_q     <= '0;
      s3_err_q   <= '0;
      s3_lvl_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_pp_q    <= s1_pp_d;
      s1_lvl_q   <= s1_lvl_d;
      s2_vld_q   <= s2_vld_d;
      s2_hi0_q   <= s2_hi0_d;
      s2_hi1_q   <= s2_hi1_d;
      s2_lo_q    <= s2_lo_d;
      s2_exact_q <= s2_exact_d;
      s2_lvl_q   <= s2_lvl_d;
      s3_vld_q   <= s3_vld_d;
      s3_p_q     <= s3_p_d;
      s3_err_q   <= s3_err_d;
      s3_lvl_q   <= s3_lvl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_rdy   = s1_free;
  assign out_vld  = s3_vld_q;
  assign out_p    = s3_p_q;
  assign out_err  = s3_err_q;
  assign out_lvl  = s3_lvl_q;
  assign stat_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ercm_pipe_mult.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_ercm_pipe_mult : directed and randomized scoreboard bench (Rev 1.0)
// ============================================================================
module tb_ercm_pipe_mult;

  localparam int W  = 8;
  localparam int LW = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_vld = 1'b0;
  logic          out_rdy = 1'b0;
  logic          stat_clr = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [LW-1:0] in_lvl = '0;

  wire           in_rdy, out_vld;
  wire [PW-1:0]  out_p, out_err;
  wire [LW-1:0]  out_lvl;
  wire [15:0]    stat_cnt;

  wire           in_rdy4, out_vld4;
  wire [PW-1:0]  out_p4, out_err4;
  wire [LW-1:0]  out_lvl4;
  wire [3:0]     stat_cnt4;

  always #5 clk = ~clk;

  ercm_pipe_mult #(.W(W), .LW(LW), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_a(in_a), .in_b(in_b), .in_lvl(in_lvl),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_p(out_p), .out_err(out_err),
    .out_lvl(out_lvl), .stat_cnt(stat_cnt), .stat_clr(stat_clr)
  );

  ercm_pipe_mult #(.W(W), .LW(LW), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy4),
    .in_a(in_a), .in_b(in_b), .in_lvl(in_lvl),
    .out_vld(out_vld4), .out_rdy(out_rdy), .out_p(out_p4), .out_err(out_err4),
    .out_lvl(out_lvl4), .stat_cnt(stat_cnt4), .stat_clr(stat_clr)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [PW-1:0] p;
    logic [PW-1:0] e;
    logic [LW-1:0] k;
  } exp_t;

  // Product minus, for each column below k, its bit count times weight, plus one weight if any bit set.
  function automatic exp_t model(input int a, input int b, input int k);
    exp_t   r;
    longint exact;
    longint approx;
    int     n;
    exact  = longint'(a) * longint'(b);
    approx = exact;
    for (int c = 0; c < k; c++) begin
      n = 0;
      for (int i = 0; i < W; i++) begin
        if ((c - i >= 0) && (c - i < W) && (((a >> i) & 1) == 1) && (((b >> (c - i)) & 1) == 1)) n++;
      end
      approx = approx - longint'(n) * (longint'(1) << c);
      if (n > 0) approx = approx + (longint'(1) << c);
    end
    r.p = PW'(approx);
    r.e = PW'(exact - approx);
    r.k = LW'(k);
    return r;
  endfunction

  exp_t          q[$];
  int            m_cnt16 = 0;
  int            m_cnt4 = 0;
  logic          stall_prev = 1'b0;
  logic [PW-1:0] sv_p, sv_e;
  logic [LW-1:0] sv_k;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic err_nz;
    if (!rst_n) begin
      q.delete();
      m_cnt16    = 0;
      m_cnt4     = 0;
      stall_prev = 1'b0;
    end else begin
      err_nz = 1'b0;
      if (stall_prev) begin
        chk("hold_vld", out_vld, 1);
        chk("hold_p", out_p, sv_p);
        chk("hold_err", out_err, sv_e);
        chk("hold_lvl", out_lvl, sv_k);
      end
      chk("stat_cnt", stat_cnt, m_cnt16);
      chk("stat_cnt4", stat_cnt4, m_cnt4);
      if (out_vld && out_rdy) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_vld, 0);
        end else begin
          e = q.pop_front();
          chk("out_p", out_p, e.p);
          chk("out_err", out_err, e.e);
          chk("out_lvl", out_lvl, e.k);
          err_nz = (e.e != 0);
        end
      end
      if (in_vld && in_rdy) q.push_back(model(in_a, in_b, in_lvl));
      if (stat_clr) begin
        m_cnt16 = 0;
        m_cnt4  = 0;
      end else if (err_nz) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      stall_prev = out_vld && !out_rdy;
      sv_p = out_p;
      sv_e = out_err;
      sv_k = out_lvl;
    end
  end

  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic [3:0] k,
                          input logic [15:0] ep, input logic [15:0] ee, input int dc);
    int          lat;
    logic [15:0] c0;
    @(posedge clk); #1;
    c0 = stat_cnt;
    in_a = a; in_b = b; in_lvl = k; in_vld = 1'b1; out_rdy = 1'b1; stat_clr = 1'b0;
    @(negedge clk);
    chk("send_rdy", in_rdy, 1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_vld) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 3);
    chk("dir_p", out_p, ep);
    chk("dir_err", out_err, ee);
    chk("dir_lvl", out_lvl, k);
    @(posedge clk); #1;
    chk("cnt_delta", stat_cnt, c0 + 16'(dc));
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_vld = 1'b0; out_rdy = 1'b1; stat_clr = 1'b0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic burst8();
    int   cyc, sent, got, last;
    logic acc, drop;
    cyc = 0; sent = 0; got = 0; last = -1; drop = 1'b0;
    @(posedge clk); #1;
    in_a = 8'($urandom); in_b = 8'($urandom); in_lvl = 4'($urandom_range(0, 15));
    while ((sent < 8 || got < 8) && cyc < 60) begin
      out_rdy = !(cyc >= 4 && cyc <= 7);
      in_vld  = (sent < 8);
      @(negedge clk);
      acc = in_vld && in_rdy;
      if (in_vld && !in_rdy) drop = 1'b1;
      if (out_vld && out_rdy) begin
        got++;
        last = cyc;
      end
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        in_a = 8'($urandom); in_b = 8'($urandom); in_lvl = 4'($urandom_range(0, 15));
      end
      cyc++;
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    chk("burst_rdy_drop", drop, 1);
    chk("burst_got", got, 8);
    chk("burst_last_cyc", last, 14);
  endtask

  task automatic random_run(input int nvec);
    int   accn, cyc;
    logic acc;
    accn = 0; cyc = 0;
    @(posedge clk); #1;
    in_vld = 1'b0;
    while (accn < nvec && cyc < 40000) begin
      if (!in_vld) begin
        in_vld = ($urandom_range(0, 3) != 0);
        in_a = 8'($urandom); in_b = 8'($urandom); in_lvl = 4'($urandom_range(0, 15));
      end
      out_rdy  = ($urandom_range(0, 3) != 0);
      stat_clr = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      acc = in_vld && in_rdy;
      @(posedge clk); #1;
      if (acc) begin
        accn++;
        in_vld = 1'b0;
      end
      cyc++;
    end
    chk("rand_accepted", accn, nvec);
    drain();
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_lvl", out_lvl, 0);
    chk("rst_stat_cnt", stat_cnt, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_rdy", in_rdy, 1);

    send_one(8'hFF, 8'hFF, 4'd0, 16'hFE01, 16'h0000, 0);
    send_one(8'hFF, 8'hFF, 4'd4, 16'hFDDF, 16'h0022, 1);
    send_one(8'h03, 8'h03, 4'd2, 16'h0007, 16'h0002, 1);

    burst8();
    drain();

    random_run(10000);

    // Saturation of the narrow counter.
    @(posedge clk); #1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    in_a = 8'hFF; in_b = 8'hFF; in_lvl = 4'd4; out_rdy = 1'b1; in_vld = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    drain();
    chk("sat_cnt4", stat_cnt4, 4'hF);
    chk("sat_cnt16", stat_cnt, 16'd20);

    // Asynchronous reset with three transactions in flight.
    out_rdy = 1'b0; in_vld = 1'b1;
    in_a = 8'h5A; in_b = 8'hC3; in_lvl = 4'd6;
    repeat (3) @(posedge clk);
    #1;
    in_vld = 1'b0;
    @(negedge clk);
    chk("pre_rst_full", out_vld, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_vld", out_vld, 0);
    chk("async_stat_cnt", stat_cnt, 0);
    chk("async_stat_cnt4", stat_cnt4, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale", out_vld, 0);
    end
    send_one(8'h03, 8'h03, 4'd2, 16'h0007, 16'h0002, 1);
    send_one(8'hFF, 8'hFF, 4'd4, 16'hFDDF, 16'h0022, 1);

    // Clear in the same cycle as an error-result transfer.
    @(posedge clk); #1;
    out_rdy = 1'b0; in_vld = 1'b1;
    in_a = 8'hFF; in_b = 8'hFF; in_lvl = 4'd4;
    @(posedge clk); #1;
    in_vld = 1'b0;
    n = 0;
    while (!out_vld && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clr_wait_vld", out_vld, 1);
    out_rdy = 1'b1; stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("clr_wins_cnt", stat_cnt, 0);
    chk("clr_wins_cnt4", stat_cnt4, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
